nav_controller: RTL and testbench

Turns eight raw navigation buttons into the fractal view parameters (centre, zoom, iteration limit) consumed by the Mandelbrot engine. It synchronises and debounces the buttons, applies pan/zoom/iteration steps with auto-repeat, and commits changes only at frame start. The view therefore never changes mid-frame. It sits between the `uio_in` pads and the engine's `center_x`/`center_y`/`zoom_level`/`max_iter_limit` inputs, in the `clk` domain.

---
 rtl/fractal_nav_pkg.sv | 19 +
 rtl/button_debouncer.sv | 29 ++
 rtl/nav_controller.sv | 154 +++++++++++++++
 tb/tb_nav_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_nav_pkg.sv
// Shared constants for the fractal view navigation controller.
package fractal_nav_pkg;

  localparam int BTN_UP       = 0;
  localparam int BTN_DOWN     = 1;
  localparam int BTN_LEFT     = 2;
  localparam int BTN_RIGHT    = 3;
  localparam int BTN_ZOOM_IN  = 4;
  localparam int BTN_ZOOM_OUT = 5;
  localparam int BTN_ITER_INC = 6;
  localparam int BTN_ITER_DEC = 7;

  localparam logic signed [15:0] CX_RESET = 16'shF800;
  localparam logic signed [15:0] CY_RESET = 16'sh0000;
  localparam logic signed [15:0] PAN_BASE = 16'sh0400;
  localparam logic [5:0]         ITER_RESET = 6'd32;
  localparam logic [5:0]         ITER_MIN   = 6'd4;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser feeding a 3-sample history taken on the shared tick.
module button_debouncer (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic btn_db_o
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;
  logic       db_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (tick_i) hist_q <= {hist_q[1:0], sync_q[1]};
      if (hist_q == 3'b111)      db_q <= 1'b1;
      else if (hist_q == 3'b000) db_q <= 1'b0;
    end
  end

  assign btn_db_o = db_q;

endmodule

// File: rtl/nav_controller.sv
// Debounced buttons drive pan/zoom/iteration view parameters, committed only at frame start.
module nav_controller
  import fractal_nav_pkg::*;
#(
  parameter int COORD_WIDTH   = 16,
  parameter int ZOOM_WIDTH    = 8,
  parameter int ITER_WIDTH    = 6,
  parameter int ZOOM_MAX      = 11,
  parameter int TICK_LOG2     = 4,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          v_begin,
  input  logic [7:0]                    btn,
  output logic signed [COORD_WIDTH-1:0] centre_x,
  output logic signed [COORD_WIDTH-1:0] centre_y,
  output logic [ZOOM_WIDTH-1:0]         zoom_level,
  output logic [ITER_WIDTH-1:0]         max_iter_limit,
  output logic                          params_updated
);

  localparam int CNT_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_FRAMES - 1);
  localparam logic signed [COORD_WIDTH:0] C_MAX = {2'b00, {(COORD_WIDTH-1){1'b1}}};
  localparam logic signed [COORD_WIDTH:0] C_MIN = {2'b11, {(COORD_WIDTH-1){1'b0}}};
  localparam logic signed [COORD_WIDTH-1:0] PAN_BASE_W = COORD_WIDTH'(PAN_BASE);
  localparam logic [ZOOM_WIDTH-1:0] Z_MAX = ZOOM_WIDTH'(ZOOM_MAX);
  localparam logic [ITER_WIDTH-1:0] I_MAX = '1;
  localparam logic [ITER_WIDTH-1:0] I_MIN = ITER_WIDTH'(ITER_MIN);

  function automatic logic signed [COORD_WIDTH-1:0] sat_coord(input logic signed [COORD_WIDTH:0] v);
    if (v > C_MAX)      return C_MAX[COORD_WIDTH-1:0];
    else if (v < C_MIN) return C_MIN[COORD_WIDTH-1:0];
    else                return v[COORD_WIDTH-1:0];
  endfunction

  logic [TICK_LOG2-1:0] presc_q;
  logic                 tick;
  logic [7:0]           btn_db;
  logic                 v_begin_q, v_begin_qq, frame;

  logic [7:0]           held_q, held_d, fire;
  logic [CNT_W-1:0]     cnt_q [8];
  logic [CNT_W-1:0]     cnt_d [8];

  logic signed [COORD_WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [ZOOM_WIDTH-1:0]         zoom_q, zoom_d;
  logic [ITER_WIDTH-1:0]         iter_q, iter_d;
  logic                          upd_q, upd_d;

  logic signed [COORD_WIDTH-1:0] pan_shift, pan_step;
  logic signed [COORD_WIDTH:0]   step_ext, cx_ext, cy_ext;
  logic signed [COORD_WIDTH-1:0] cx_plus, cx_minus, cy_plus, cy_minus;

  assign tick  = (presc_q == '0);
  assign frame = v_begin_q & ~v_begin_qq;

  for (genvar i = 0; i < 8; i++) begin : g_btn
    button_debouncer u_db (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .btn_i    (btn[i]),
      .btn_db_o (btn_db[i])
    );
  end

  // Repeat counter only advances on frames, so a held button fires every REPEAT_FRAMES frames.
  always_comb begin
    fire   = '0;
    held_d = held_q;
    cnt_d  = cnt_q;
    if (frame) begin
      held_d = btn_db;
      for (int i = 0; i < 8; i++) begin
        if (!btn_db[i]) begin
          cnt_d[i] = '0;
        end else if (!held_q[i] || cnt_q[i] == CNT_LAST) begin
          fire[i]  = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Step comes from the zoom level registered before this frame's update.
  assign pan_shift = PAN_BASE_W >>> zoom_q;
  assign pan_step  = (pan_shift == '0) ? {{(COORD_WIDTH-1){1'b0}}, 1'b1} : pan_shift;
  assign step_ext  = {pan_step[COORD_WIDTH-1], pan_step};
  assign cx_ext    = {cx_q[COORD_WIDTH-1], cx_q};
  assign cy_ext    = {cy_q[COORD_WIDTH-1], cy_q};
  assign cx_plus   = sat_coord(cx_ext + step_ext);
  assign cx_minus  = sat_coord(cx_ext - step_ext);
  assign cy_plus   = sat_coord(cy_ext + step_ext);
  assign cy_minus  = sat_coord(cy_ext - step_ext);

  always_comb begin
    cx_d   = cx_q;
    cy_d   = cy_q;
    zoom_d = zoom_q;
    iter_d = iter_q;
    if (frame) begin
      if (fire[BTN_UP] && !fire[BTN_DOWN])         cy_d = cy_minus;
      else if (fire[BTN_DOWN] && !fire[BTN_UP])    cy_d = cy_plus;
      if (fire[BTN_LEFT] && !fire[BTN_RIGHT])      cx_d = cx_minus;
      else if (fire[BTN_RIGHT] && !fire[BTN_LEFT]) cx_d = cx_plus;
      if (fire[BTN_ZOOM_IN] && !fire[BTN_ZOOM_OUT])
        zoom_d = (zoom_q >= Z_MAX) ? Z_MAX : zoom_q + ZOOM_WIDTH'(1);
      else if (fire[BTN_ZOOM_OUT] && !fire[BTN_ZOOM_IN])
        zoom_d = (zoom_q == '0) ? '0 : zoom_q - ZOOM_WIDTH'(1);
      if (fire[BTN_ITER_INC] && !fire[BTN_ITER_DEC])
        iter_d = (iter_q == I_MAX) ? I_MAX : iter_q + ITER_WIDTH'(1);
      else if (fire[BTN_ITER_DEC] && !fire[BTN_ITER_INC])
        iter_d = (iter_q <= I_MIN) ? I_MIN : iter_q - ITER_WIDTH'(1);
    end
    upd_d = (cx_d != cx_q) || (cy_d != cy_q) || (zoom_d != zoom_q) || (iter_d != iter_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      v_begin_q  <= 1'b0;
      v_begin_qq <= 1'b0;
      held_q     <= '0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      cx_q       <= COORD_WIDTH'(CX_RESET);
      cy_q       <= COORD_WIDTH'(CY_RESET);
      zoom_q     <= '0;
      iter_q     <= ITER_WIDTH'(ITER_RESET);
      upd_q      <= 1'b0;
    end else begin
      presc_q    <= presc_q - TICK_LOG2'(1);
      v_begin_q  <= v_begin;
      v_begin_qq <= v_begin_q;
      held_q     <= held_d;
      cnt_q      <= cnt_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      zoom_q     <= zoom_d;
      iter_q     <= iter_d;
      upd_q      <= upd_d;
    end
  end

  assign centre_x       = cx_q;
  assign centre_y       = cy_q;
  assign zoom_level     = zoom_q;
  assign max_iter_limit = iter_q;
  assign params_updated = upd_q;

endmodule

// File: tb/tb_nav_controller.sv
// Randomised and directed bench for nav_controller with a frame-level reference model and pulse scoreboard.
module tb_nav_controller;

  localparam int SETTLE = 90;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               v_begin = 1'b0;
  logic [7:0]         btn = 8'hFF;
  logic signed [15:0] centre_x, centre_y;
  logic [7:0]         zoom_level;
  logic [5:0]         max_iter_limit;
  logic               params_updated;

  nav_controller dut (
    .clk            (clk),
    .rst            (rst),
    .v_begin        (v_begin),
    .btn            (btn),
    .centre_x       (centre_x),
    .centre_y       (centre_y),
    .zoom_level     (zoom_level),
    .max_iter_limit (max_iter_limit),
    .params_updated (params_updated)
  );

  always #5 clk = ~clk;

  typedef struct { int cx; int cy; int zoom; int iter; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int n_pulse = 0;

  int m_cx, m_cy, m_zoom, m_iter;
  int m_held [8];
  logic [7:0] last_btn = 8'h00;

  task automatic chk(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic chk_outputs(input string name);
    chk({name, "_cx"},   int'(centre_x), m_cx);
    chk({name, "_cy"},   int'(centre_y), m_cy);
    chk({name, "_zoom"}, int'(zoom_level), m_zoom);
    chk({name, "_iter"}, int'(max_iter_limit), m_iter);
  endtask

  task automatic model_reset();
    m_cx = -2048; m_cy = 0; m_zoom = 0; m_iter = 32;
    for (int i = 0; i < 8; i++) m_held[i] = 0;
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // One frame of the view rules, given which buttons are debounced-pressed at that frame.
  task automatic model_frame(input logic [7:0] b);
    bit f [8];
    int step;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      m_held[i] = b[i] ? m_held[i] + 1 : 0;
      f[i] = b[i] && ((m_held[i] - 1) % 8 == 0);
    end
    step = 1024 >> m_zoom;
    if (step < 1) step = 1;
    e.cx = m_cx; e.cy = m_cy; e.zoom = m_zoom; e.iter = m_iter;
    if (f[0] && !f[1]) e.cy = clamp(m_cy - step, -32768, 32767);
    if (f[1] && !f[0]) e.cy = clamp(m_cy + step, -32768, 32767);
    if (f[2] && !f[3]) e.cx = clamp(m_cx - step, -32768, 32767);
    if (f[3] && !f[2]) e.cx = clamp(m_cx + step, -32768, 32767);
    if (f[4] && !f[5]) e.zoom = clamp(m_zoom + 1, 0, 11);
    if (f[5] && !f[4]) e.zoom = clamp(m_zoom - 1, 0, 11);
    if (f[6] && !f[7]) e.iter = clamp(m_iter + 1, 4, 63);
    if (f[7] && !f[6]) e.iter = clamp(m_iter - 1, 4, 63);
    if (e.cx != m_cx || e.cy != m_cy || e.zoom != m_zoom || e.iter != m_iter)
      exp_q.push_back(e);
    m_cx = e.cx; m_cy = e.cy; m_zoom = e.zoom; m_iter = e.iter;
  endtask

  task automatic do_frame(input logic [7:0] b_drive, input logic [7:0] b_eff,
                          input bit force_settle, input int vlen);
    btn = b_drive;
    if (force_settle || b_drive != last_btn) repeat (SETTLE) @(posedge clk);
    last_btn = b_drive;
    model_frame(b_eff);
    #1 v_begin = 1'b1;
    repeat (vlen) @(posedge clk);
    #1 v_begin = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b);
    do_frame(b, b, 1'b0, $urandom_range(1, 8));
  endtask

  always @(negedge clk) begin
    if (!rst && params_updated) begin
      exp_t e;
      n_cmp++;
      n_pulse++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse%0d: unexpected params_updated with cx=%0d cy=%0d zoom=%0d iter=%0d, want no pulse",
                 n_pulse, centre_x, centre_y, zoom_level, max_iter_limit);
      end else begin
        e = exp_q.pop_front();
        if (int'(centre_x) != e.cx || int'(centre_y) != e.cy ||
            int'(zoom_level) != e.zoom || int'(max_iter_limit) != e.iter) begin
          n_fail++;
          $display("FAIL pulse%0d: got cx=%0d cy=%0d zoom=%0d iter=%0d, want cx=%0d cy=%0d zoom=%0d iter=%0d",
                   n_pulse, centre_x, centre_y, zoom_level, max_iter_limit, e.cx, e.cy, e.zoom, e.iter);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int guard;
    model_reset();

    // Reset held with all buttons pressed
    repeat (5) begin
      @(negedge clk);
      chk_outputs("reset");
      chk("reset_pulse", params_updated, 0);
    end
    @(posedge clk); #1;
    btn = 8'h00;
    rst = 1'b0;
    frame(8'h00);
    frame(8'h00);

    // Bouncing right button must never qualify
    for (int i = 0; i < 40; i++) begin
      btn[3] = ~btn[3];
      repeat (5) @(posedge clk);
      #1;
    end
    btn = 8'h00;
    repeat (100) @(posedge clk);
    #1;
    frame(8'h00);
    chk("glitch_cx", int'(centre_x), -2048);

    // Clean right press
    frame(8'h08);
    chk("right_cx", int'(centre_x), -1024);
    frame(8'h00);

    // Zoom to 3, then hold up for 17 frames
    repeat (3) begin frame(8'h10); frame(8'h00); end
    repeat (17) frame(8'h01);
    frame(8'h00);
    chk("pan_repeat_cy", int'(centre_y), -384);

    // Zoom saturation
    repeat (200) frame(8'h10);
    frame(8'h00);
    chk("zoom_sat", int'(zoom_level), 11);
    repeat (90) frame(8'h20);
    frame(8'h00);
    chk("zoom_floor", int'(zoom_level), 0);

    // Walk centre_x up to 0x7F00, then saturate
    guard = 0;
    while (m_cx != 32'sh7C00 && guard < 40) begin
      frame(8'h08); frame(8'h00);
      guard++;
    end
    repeat (2) begin frame(8'h10); frame(8'h00); end
    repeat (3) begin frame(8'h08); frame(8'h00); end
    chk("cx_7f00", int'(centre_x), 32512);
    repeat (2) begin frame(8'h20); frame(8'h00); end
    frame(8'h08); frame(8'h00);
    chk("cx_sat", int'(centre_x), 32767);
    frame(8'h08); frame(8'h00);

    // Iteration floor
    repeat (230) frame(8'h80);
    frame(8'h00);
    chk("iter_floor", int'(max_iter_limit), 4);

    // Opposing up+down with zoom_in
    frame(8'h13);
    frame(8'h00);

    // Long v_begin high counts once
    do_frame(8'h04, 8'h04, 1'b0, 50);
    frame(8'h00);

    // Reset right after a press qualifies
    btn = 8'h01;
    repeat (SETTLE) @(posedge clk);
    last_btn = 8'h01;
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk_outputs("mid_reset");
    @(posedge clk); #1;
    do_frame(8'h01, 8'h00, 1'b0, 2);
    chk_outputs("post_reset");
    do_frame(8'h01, 8'h01, 1'b1, 3);
    frame(8'h00);

    // Random button patterns
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1) b = last_btn;
      else b = 8'($urandom & $urandom);
      frame(b);
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk_outputs("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
